game_state_ctrl: RTL and testbench

- Top-level game controller that sits directly downstream of the stickman sprite block.
- Each pixel clock it consumes `is_stickman`, plus `is_obstacle` from the obstacle block, and detects pixel-exact collision during the active frame.
- Runs the IDLE/PLAY/OVER game state machine and drives the `restart` input of the stickman and obstacle blocks.
- Keeps the running score, high score and speed level for the color mapper and obstacle scroller.

---
 rtl/game_state_ctrl.sv | 138 +++++++++++++
 tb/tb_game_state_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// Game controller: frame-strobe edge detect, pixel collision latch, IDLE/PLAY/OVER
// state machine, score / high-score / speed-level bookkeeping for the display path.
module game_state_ctrl #(
  parameter int         SCORE_DIV  = 6,
  parameter int         LEVEL_STEP = 100,
  parameter int         MAX_LEVEL  = 7,
  parameter int         MAX_SCORE  = 9999,
  parameter logic [7:0] KEY_START  = 8'h2C
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        is_stickman,
  input  logic        is_obstacle,
  output logic        restart,
  output logic        freeze,
  output logic        running,
  output logic        game_over,
  output logic [13:0] score,
  output logic [13:0] high_score,
  output logic [2:0]  speed_level
);

  localparam int FW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int LW = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t        state, state_nxt;
  logic          frame_d, fe, key_prev, hit;
  logic          key_now, key_press, pix_hit;
  logic          enter_play, enter_over, tick;
  logic [FW-1:0] frame_cnt;
  logic [LW-1:0] level_cnt;

  assign key_now   = (keycode == KEY_START);
  assign key_press = key_now & ~key_prev;
  assign pix_hit   = (state == PLAY) && is_stickman && is_obstacle &&
                     (DrawX < 10'd640) && (DrawY < 10'd480);

  always_comb begin
    state_nxt  = state;
    enter_play = 1'b0;
    enter_over = 1'b0;
    tick       = 1'b0;
    if (fe) begin
      case (state)
        IDLE: if (key_press) begin
          state_nxt  = PLAY;
          enter_play = 1'b1;
        end
        PLAY: if (hit) begin
          // A pending collision wins over the score tick of the same frame.
          state_nxt  = OVER;
          enter_over = 1'b1;
        end else begin
          tick = 1'b1;
        end
        OVER: if (key_press) begin
          state_nxt  = PLAY;
          enter_play = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      restart   <= 1'b1;
      freeze    <= 1'b0;
      running   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      restart   <= (state_nxt == IDLE) | enter_play;
      freeze    <= (state_nxt == OVER);
      running   <= (state_nxt == PLAY);
      game_over <= (state_nxt == OVER);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_d     <= 1'b0;
      fe          <= 1'b0;
      key_prev    <= 1'b0;
      hit         <= 1'b0;
      frame_cnt   <= '0;
      level_cnt   <= '0;
      score       <= '0;
      high_score  <= '0;
      speed_level <= '0;
    end else begin
      frame_d <= frame_clk;
      fe      <= frame_clk & ~frame_d;
      if (fe)
        key_prev <= key_now;
      // Set beats clear so a hit on the fe cycle carries into the next frame.
      if (pix_hit)
        hit <= 1'b1;
      else if (fe)
        hit <= 1'b0;

      if (enter_play) begin
        frame_cnt   <= '0;
        level_cnt   <= '0;
        score       <= '0;
        speed_level <= '0;
      end else if (tick) begin
        if (frame_cnt == FW'(SCORE_DIV - 1)) begin
          frame_cnt <= '0;
          if (score != 14'(MAX_SCORE)) begin
            score <= score + 14'd1;
            // level_cnt mirrors score modulo LEVEL_STEP, avoiding a divider.
            if (level_cnt == LW'(LEVEL_STEP - 1)) begin
              level_cnt <= '0;
              if (speed_level != 3'(MAX_LEVEL))
                speed_level <= speed_level + 3'd1;
            end else begin
              level_cnt <= level_cnt + LW'(1);
            end
          end
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end

      if (enter_over && (score > high_score))
        high_score <= score;
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed vector table, hand-written game sequences and
// random frames, all checked against a frame-level reference model.
module tb_game_state_ctrl;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       rst, fclk, stk, obs;
  logic [7:0] key;
  logic [9:0] dx, dy;

  logic        restart_o[2], freeze_o[2], running_o[2], over_o[2];
  logic [13:0] score_o[2], high_o[2];
  logic [2:0]  level_o[2];

  game_state_ctrl u_main (
    .Clk(Clk), .Reset(rst), .frame_clk(fclk), .keycode(key), .DrawX(dx), .DrawY(dy),
    .is_stickman(stk), .is_obstacle(obs),
    .restart(restart_o[0]), .freeze(freeze_o[0]), .running(running_o[0]),
    .game_over(over_o[0]), .score(score_o[0]), .high_score(high_o[0]),
    .speed_level(level_o[0])
  );

  // Small-parameter copy that never collides, used to reach both saturation limits.
  game_state_ctrl #(.SCORE_DIV(2), .LEVEL_STEP(5), .MAX_LEVEL(7), .MAX_SCORE(50)) u_sat (
    .Clk(Clk), .Reset(rst), .frame_clk(fclk), .keycode(key), .DrawX(dx), .DrawY(dy),
    .is_stickman(stk), .is_obstacle(1'b0),
    .restart(restart_o[1]), .freeze(freeze_o[1]), .running(running_o[1]),
    .game_over(over_o[1]), .score(score_o[1]), .high_score(high_o[1]),
    .speed_level(level_o[1])
  );

  int vectors = 0;
  int miscompares = 0;

  int p_sd[2]   = '{6, 2};
  int p_step[2] = '{100, 5};
  int p_maxl[2] = '{7, 7};
  int p_maxs[2] = '{9999, 50};

  // Model: mode 0 = idle, 1 = play, 2 = over; m_n counts scoring frames in the current game.
  int m_mode[2];
  int m_n[2];
  int m_high[2];
  bit m_fd[2], m_fe[2], m_kprev[2], m_hit[2], m_pulse[2];

  function automatic int m_score(input int i);
    int s;
    s = m_n[i] / p_sd[i];
    return (s > p_maxs[i]) ? p_maxs[i] : s;
  endfunction

  function automatic int m_level(input int i);
    int l;
    l = m_score(i) / p_step[i];
    return (l > p_maxl[i]) ? p_maxl[i] : l;
  endfunction

  task automatic model_edge(input int i, input bit o);
    bit fe_old, kn, kp, pix;
    fe_old = m_fe[i];
    kn     = (key == 8'h2C);
    kp     = kn && !m_kprev[i];
    pix    = (m_mode[i] == 1) && stk && o && (dx < 10'd640) && (dy < 10'd480);
    if (rst) begin
      m_mode[i] = 0; m_n[i] = 0; m_high[i] = 0;
      m_fd[i] = 0; m_fe[i] = 0; m_kprev[i] = 0; m_hit[i] = 0; m_pulse[i] = 0;
    end else begin
      m_pulse[i] = 0;
      if (fe_old) begin
        if (m_mode[i] == 1) begin
          if (m_hit[i]) begin
            m_mode[i] = 2;
            if (m_score(i) > m_high[i]) m_high[i] = m_score(i);
          end else begin
            m_n[i]++;
          end
        end else if (kp) begin
          m_mode[i] = 1; m_n[i] = 0; m_pulse[i] = 1;
        end
        m_kprev[i] = kn;
      end
      if (pix) m_hit[i] = 1;
      else if (fe_old) m_hit[i] = 0;
      m_fe[i] = fclk && !m_fd[i];
      m_fd[i] = fclk;
    end
  endtask

  task automatic check_inst(input int i);
    logic [34:0] act, exp;
    act = {restart_o[i], freeze_o[i], running_o[i], over_o[i], score_o[i], high_o[i], level_o[i]};
    exp = {(m_mode[i] == 0) || m_pulse[i], m_mode[i] == 2, m_mode[i] == 1, m_mode[i] == 2,
           14'(m_score(i)), 14'(m_high[i]), 3'(m_level(i))};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL model_u%0d t=%0t got rst/frz/run/ovr=%b score=%0d high=%0d lvl=%0d, want rst/frz/run/ovr=%b score=%0d high=%0d lvl=%0d",
               i, $time, act[34:31], act[30:17], act[16:3], act[2:0],
               exp[34:31], exp[30:17], exp[16:3], exp[2:0]);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    model_edge(0, obs);
    model_edge(1, 1'b0);
    @(posedge Clk);
    @(negedge Clk);
    check_inst(0);
    check_inst(1);
  endtask

  task automatic set_pix(input bit on, input int x, input int y);
    stk = on; obs = on; dx = 10'(x); dy = 10'(y);
  endtask

  // coll: 0 none, 1 on-screen pixel after fe, 2 on-screen pixel on the fe cycle, 3 off-screen pixel
  task automatic frame(input int coll);
    fclk = 1'b1; cyc();
    fclk = 1'b1; if (coll == 2) set_pix(1, 120, 300);
    cyc(); set_pix(0, 0, 0);
    fclk = 1'b0;
    if (coll == 1) set_pix(1, 120, 300);
    if (coll == 3) set_pix(1, 700, 300);
    cyc(); set_pix(0, 0, 0);
    fclk = 1'b0; cyc();
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) frame(0);
  endtask

  task automatic rand_cycle(input bit level);
    fclk = level;
    rst  = ($urandom_range(0, 299) == 0);
    if ($urandom_range(0, 11) == 0) set_pix(1, $urandom_range(0, 800), $urandom_range(0, 600));
    else set_pix(0, 0, 0);
    cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    bit         fc;
    logic [7:0] key;
    bit         pix;
    int         x;
    int         y;
    bit         e_restart;
    bit         e_run;
    bit         e_over;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input bit r, input bit f, input logic [7:0] k, input bit p,
                              input int x, input int y, input bit er, input bit eu, input bit eo);
    vec_t v;
    v.rst = r; v.fc = f; v.key = k; v.pix = p; v.x = x; v.y = y;
    v.e_restart = er; v.e_run = eu; v.e_over = eo;
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(1, 0, 8'h00, 0,   0,   0, 1, 0, 0);
    tbl[1]  = mk(0, 0, 8'h2C, 0,   0,   0, 1, 0, 0);
    tbl[2]  = mk(0, 1, 8'h2C, 0,   0,   0, 1, 0, 0);
    tbl[3]  = mk(0, 1, 8'h2C, 0,   0,   0, 1, 1, 0);
    tbl[4]  = mk(0, 0, 8'h2C, 0,   0,   0, 0, 1, 0);
    tbl[5]  = mk(0, 0, 8'h2C, 1, 639, 480, 0, 1, 0);
    tbl[6]  = mk(0, 1, 8'h2C, 0,   0,   0, 0, 1, 0);
    tbl[7]  = mk(0, 1, 8'h2C, 0,   0,   0, 0, 1, 0);
    tbl[8]  = mk(0, 0, 8'h2C, 1, 700, 300, 0, 1, 0);
    tbl[9]  = mk(0, 1, 8'h2C, 0,   0,   0, 0, 1, 0);
    tbl[10] = mk(0, 1, 8'h2C, 0,   0,   0, 0, 1, 0);
    tbl[11] = mk(0, 0, 8'h2C, 1, 639, 479, 0, 1, 0);
    tbl[12] = mk(0, 1, 8'h2C, 0,   0,   0, 0, 1, 0);
    tbl[13] = mk(0, 1, 8'h2C, 0,   0,   0, 0, 0, 1);
    tbl[14] = mk(0, 0, 8'h00, 0,   0,   0, 0, 0, 1);
    tbl[15] = mk(0, 0, 8'h2C, 0,   0,   0, 0, 0, 1);

    rst = 1'b1; fclk = 1'b0; key = 8'h00; set_pix(0, 0, 0);

    for (int v = 0; v < 16; v++) begin
      rst = tbl[v].rst; fclk = tbl[v].fc; key = tbl[v].key;
      set_pix(tbl[v].pix, tbl[v].x, tbl[v].y);
      cyc();
      chk($sformatf("tbl%0d_restart", v), restart_o[0], tbl[v].e_restart);
      chk($sformatf("tbl%0d_running", v), running_o[0], tbl[v].e_run);
      chk($sformatf("tbl%0d_game_over", v), over_o[0], tbl[v].e_over);
      chk($sformatf("tbl%0d_freeze", v), freeze_o[0], tbl[v].e_over);
      chk($sformatf("tbl%0d_score", v), score_o[0], 0);
    end
    set_pix(0, 0, 0);

    // Held key across three frames gives one start and a single restart pulse.
    rst = 1'b1; fclk = 1'b0; key = 8'h00; cyc();
    chk("reset_restart", restart_o[0], 1);
    chk("reset_high", high_o[0], 0);
    rst = 1'b0; key = 8'h2C;
    fclk = 1'b1; cyc();
    chk("pre_start_running", running_o[0], 0);
    fclk = 1'b1; cyc();
    chk("start_restart_pulse", restart_o[0], 1);
    chk("start_running", running_o[0], 1);
    fclk = 1'b0; cyc();
    chk("restart_drop", restart_o[0], 0);
    fclk = 1'b0; cyc();
    frames(2);
    chk("held_key_running", running_o[0], 1);
    chk("held_key_restart", restart_o[0], 0);
    chk("held_key_score", score_o[0], 0);

    frames(58);
    chk("score_60_frames", score_o[0], 10);
    chk("level_60_frames", level_o[0], 0);
    frames(540);
    chk("score_600_frames", score_o[0], 100);
    chk("level_600_frames", level_o[0], 1);

    // Game ending at 37, with the collision landing on a score-tick frame.
    rst = 1'b1; fclk = 1'b0; cyc(); rst = 1'b0;
    frame(0);
    frames(224);
    frame(3);
    frame(0);
    chk("offscreen_running", running_o[0], 1);
    chk("offscreen_score", score_o[0], 37);
    frame(1);
    chk("pending_hit_running", running_o[0], 1);
    frame(0);
    chk("hit_game_over", over_o[0], 1);
    chk("hit_freeze", freeze_o[0], 1);
    chk("hit_score_held", score_o[0], 37);
    chk("hit_high", high_o[0], 37);

    key = 8'h00; frame(0);
    chk("release_still_over", over_o[0], 1);
    key = 8'h2C; frame(0);
    chk("replay_running", running_o[0], 1);
    chk("replay_score", score_o[0], 0);
    chk("replay_level", level_o[0], 0);
    chk("replay_high", high_o[0], 37);

    // Second game ends at 20 via a collision on the fe cycle itself.
    frames(119);
    frame(2);
    chk("fe_hit_still_play", running_o[0], 1);
    chk("fe_hit_score", score_o[0], 20);
    frame(0);
    chk("game2_over", over_o[0], 1);
    chk("game2_score", score_o[0], 20);
    chk("game2_high_kept", high_o[0], 37);

    chk("sat_score", score_o[1], 50);
    chk("sat_level", level_o[1], 7);
    frames(5);
    chk("sat_score_hold", score_o[1], 50);
    chk("sat_level_hold", level_o[1], 7);

    // Reset in the middle of a game.
    key = 8'h00; frame(0);
    key = 8'h2C; frame(0);
    frames(10);
    chk("midplay_running", running_o[0], 1);
    chk("midplay_high", high_o[0], 37);
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d_restart", i), restart_o[i], 1);
      chk($sformatf("rst%0d_freeze", i), freeze_o[i], 0);
      chk($sformatf("rst%0d_running", i), running_o[i], 0);
      chk($sformatf("rst%0d_game_over", i), over_o[i], 0);
      chk($sformatf("rst%0d_score", i), score_o[i], 0);
      chk($sformatf("rst%0d_high", i), high_o[i], 0);
      chk($sformatf("rst%0d_level", i), level_o[i], 0);
    end

    for (int f = 0; f < 400; f++) begin
      case ($urandom_range(0, 3))
        0:       key = 8'h00;
        1, 2:    key = 8'h2C;
        default: key = 8'($urandom_range(0, 255));
      endcase
      for (int c = 0; c < int'($urandom_range(1, 3)); c++) rand_cycle(1'b1);
      for (int c = 0; c < int'($urandom_range(1, 4)); c++) rand_cycle(1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
